avalon_aes_master: RTL
======================

Name: avalon_aes_master

Overview:
- Avalon-MM master that drives the AES decryption core's 16-word register map from a simple command port.
- Sequence: load the 128-bit key and ciphertext, write START, poll DONE, read back the 128-bit plaintext, clear START, report completion.
- Sits between a hardware requester (test harness or DMA front end) and the AES register slave, so the core can be exercised without the NIOS.

Parameters:
- READ_LATENCY, 1: cycles from the read-issue cycle to valid AVM_READDATA. Legal range 1..3.
- POLL_MAX, 1024: maximum number of DONE polls before timeout. Range 1..65535.
- POLL_GAP, 4: idle cycles between consecutive DONE polls. Range 0..255.

Ports:
- CLK, in, 1: system clock.
- RESET, in, 1: asynchronous, active-low reset.
- CMD_START, in, 1: single-cycle request. Accepted only in IDLE.
- CMD_KEY, in, 128: AES key. Sampled on acceptance.
- CMD_MSG_ENC, in, 128: ciphertext. Sampled on acceptance.
- CMD_BUSY, out, 1: high from the acceptance cycle until the DONE-pulse cycle, inclusive.
- CMD_DONE, out, 1: one-cycle completion pulse.
- CMD_ERR, out, 1: meaningful only with CMD_DONE. 1 = poll timeout.
- RESULT, out, 128: plaintext. Held until the next completion.
- AVM_READ, out, 1: Avalon-MM read.
- AVM_WRITE, out, 1: Avalon-MM write.
- AVM_CS, out, 1: chip select. High whenever READ or WRITE is high.
- AVM_BYTE_EN, out, 4: always 4'b1111 during an access, 0 otherwise.
- AVM_ADDR, out, 4: word address.
- AVM_WRITEDATA, out, 32: write data.
- AVM_READDATA, in, 32: read data.

Behaviour:
- Reset: all outputs 0; FSM to IDLE; poll counter and gap counter 0. Asserting reset mid-transaction aborts immediately: no further bus cycles and no DONE pulse.
- Word order: word i (i=0..3) = bits [127-32i -: 32].
  - Key word i goes to addr i.
  - Ciphertext word i goes to addr 4+i.
  - Plaintext word i is read from addr 8+i.
  - START is addr 14; DONE is addr 15.
- Write: one cycle with AVM_WRITE=AVM_CS=1, BYTE_EN=1111, addr and data valid. There is no waitrequest.
- Read: one issue cycle with AVM_READ=AVM_CS=1 and addr valid. Data is sampled at the end of cycle issue+READ_LATENCY. READ, WRITE and CS are low in between. Reads never overlap. READ and WRITE are never high together.
- FSM states:
  - IDLE: CMD_START=1 latches the inputs, sets BUSY, clears the poll count, and goes to WR_KEY.
  - WR_KEY: 4 consecutive writes, addr 0..3, then WR_MSG.
  - WR_MSG: 4 writes, addr 4..7, then WR_GO.
  - WR_GO: write 32'h1 to addr 14, then POLL_RD.
  - POLL_RD: read addr 15 and increment the poll count.
    - Sampled bit0=1 goes to RD_DEC.
    - Otherwise, if count==POLL_MAX, set the error flag and go to CLR_GO.
    - Otherwise go to POLL_WAIT.
  - POLL_WAIT: POLL_GAP idle cycles, then POLL_RD. With POLL_GAP=0, the next read issues in the cycle after sampling.
  - RD_DEC: 4 reads, addr 8..11, in order. Each sampled word goes into the RESULT shadow register.
  - CLR_GO: write 32'h0 to addr 14, then FIN.
  - FIN: CMD_DONE=1 for one cycle. On success, RESULT is updated from the shadow. On timeout, CMD_ERR=1 and RESULT is forced to 0. BUSY drops the next cycle and the FSM returns to IDLE.
- Minimum transaction (READ_LATENCY=1, DONE already set on the first poll): 9 write cycles + 2 poll cycles + 8 read cycles + 1 clear + 1 FIN = 21 cycles, counted from the acceptance-cycle edge to the DONE pulse.
- Upper bits of the DONE word are ignored.
- CMD_START while BUSY is ignored and does not queue.
- CMD_START in the FIN cycle is ignored. It is first accepted in the following IDLE cycle.
- A change on CMD_KEY or CMD_MSG_ENC after acceptance has no effect.
- The poll counter is 16 bits and never wraps, because timeout fires at POLL_MAX.

Test Plan:
- FIPS-197 vector: key 000102030405060708090a0b0c0d0e0f, ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a, slave model sets DONE 50 cycles after START=1. Required: RESULT=00112233445566778899aabbccddeeff, CMD_DONE one cycle, CMD_ERR=0, bus trace addr 0..7, 14 (data 1), polls of 15, reads 8..11, then 14 (data 0).
- DONE already high on the first poll, READ_LATENCY=1: CMD_DONE asserts exactly 21 cycles after acceptance, and exactly one poll is issued.
- DONE never set, POLL_MAX=3, POLL_GAP=2: exactly 3 reads of addr 15 spaced 4 cycles apart, then a write of 0 to addr 14, then CMD_DONE=1 with CMD_ERR=1 and RESULT=0. No reads of addr 8..11.
- CMD_START pulsed while busy, and again in the FIN cycle: neither starts a transaction. A pulse in the next IDLE cycle starts one.
- RESET driven low during RD_DEC (after 2 words read): all outputs go to 0 asynchronously, before the next edge. After release, the FSM is in IDLE, no DONE pulse appears, and a new command completes normally.
- READ_LATENCY=3 with a slave model matching that latency: correct RESULT, and each read spans 4 cycles with no overlapping issue.

Source files
------------

// File: rtl/avalon_aes_master.sv
// avalon_aes_master: drives the AES core's Avalon-MM register map from a one-shot command port.
// Loads key/ciphertext, starts the core, polls DONE, reads the plaintext and clears START.
module avalon_aes_master #(
    parameter int READ_LATENCY = 1,
    parameter int POLL_MAX     = 1024,
    parameter int POLL_GAP     = 4
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         CMD_START,
    input  logic [127:0] CMD_KEY,
    input  logic [127:0] CMD_MSG_ENC,
    output logic         CMD_BUSY,
    output logic         CMD_DONE,
    output logic         CMD_ERR,
    output logic [127:0] RESULT,
    output logic         AVM_READ,
    output logic         AVM_WRITE,
    output logic         AVM_CS,
    output logic [3:0]   AVM_BYTE_EN,
    output logic [3:0]   AVM_ADDR,
    output logic [31:0]  AVM_WRITEDATA,
    input  logic [31:0]  AVM_READDATA
);
    typedef enum logic [3:0] {IDLE, WR_KEY, WR_MSG, WR_GO, POLL_RD, POLL_WAIT, RD_DEC, CLR_GO, FIN} state_e;
    state_e       state_q, state_d;
    logic [127:0] key_q, key_d, msg_q, msg_d, shadow_q, shadow_d, result_q, result_d;
    logic [15:0]  poll_q, poll_d;
    logic [7:0]   gap_q, gap_d;
    logic [1:0]   idx_q, idx_d, lat_q, lat_d;
    logic         err_q, err_d, rd, wr, sampled;
    logic [3:0]   addr;
    logic [31:0]  wdata;
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q  <= IDLE;
            key_q    <= '0;
            msg_q    <= '0;
            shadow_q <= '0;
            result_q <= '0;
            poll_q   <= '0;
            gap_q    <= '0;
            idx_q    <= '0;
            lat_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            key_q    <= key_d;
            msg_q    <= msg_d;
            shadow_q <= shadow_d;
            result_q <= result_d;
            poll_q   <= poll_d;
            gap_q    <= gap_d;
            idx_q    <= idx_d;
            lat_q    <= lat_d;
            err_q    <= err_d;
        end
    end
    // Key and message rotate left one word per write, so the word on the bus is always bits [127:96].
    always_comb begin
        state_d  = state_q;
        key_d    = key_q;
        msg_d    = msg_q;
        shadow_d = shadow_q;
        result_d = result_q;
        poll_d   = poll_q;
        gap_d    = gap_q;
        idx_d    = idx_q;
        lat_d    = lat_q;
        err_d    = err_q;
        rd       = 1'b0;
        wr       = 1'b0;
        addr     = 4'd0;
        wdata    = 32'd0;
        sampled  = lat_q == 2'(READ_LATENCY);
        case (state_q)
            IDLE: if (CMD_START) begin
                state_d = WR_KEY;
                key_d   = CMD_KEY;
                msg_d   = CMD_MSG_ENC;
                poll_d  = '0;
                err_d   = 1'b0;
                idx_d   = '0;
            end
            WR_KEY: begin
                wr      = 1'b1;
                addr    = {2'b00, idx_q};
                wdata   = key_q[127:96];
                key_d   = {key_q[95:0], key_q[127:96]};
                idx_d   = idx_q + 2'd1;
                state_d = idx_q == 2'd3 ? WR_MSG : WR_KEY;
            end
            WR_MSG: begin
                wr      = 1'b1;
                addr    = {2'b01, idx_q};
                wdata   = msg_q[127:96];
                msg_d   = {msg_q[95:0], msg_q[127:96]};
                idx_d   = idx_q + 2'd1;
                state_d = idx_q == 2'd3 ? WR_GO : WR_MSG;
            end
            WR_GO: begin
                wr      = 1'b1;
                addr    = 4'd14;
                wdata   = 32'd1;
                lat_d   = '0;
                state_d = POLL_RD;
            end
            POLL_RD: begin
                rd     = lat_q == 2'd0;
                addr   = rd ? 4'd15 : 4'd0;
                lat_d  = sampled ? 2'd0 : lat_q + 2'd1;
                poll_d = rd ? poll_q + 16'd1 : poll_q;
                gap_d  = '0;
                if (sampled) begin
                    if (AVM_READDATA[0]) begin
                        state_d = RD_DEC;
                        idx_d   = '0;
                    end else if (poll_q == 16'(POLL_MAX)) begin
                        err_d   = 1'b1;
                        state_d = CLR_GO;
                    end else
                        state_d = (POLL_GAP == 0) ? POLL_RD : POLL_WAIT;
                end
            end
            POLL_WAIT: begin
                gap_d   = gap_q == 8'(POLL_GAP - 1) ? 8'd0 : gap_q + 8'd1;
                state_d = gap_q == 8'(POLL_GAP - 1) ? POLL_RD : POLL_WAIT;
            end
            RD_DEC: begin
                rd    = lat_q == 2'd0;
                addr  = rd ? {2'b10, idx_q} : 4'd0;
                lat_d = sampled ? 2'd0 : lat_q + 2'd1;
                if (sampled) begin
                    shadow_d = {shadow_q[95:0], AVM_READDATA};
                    idx_d    = idx_q + 2'd1;
                    state_d  = idx_q == 2'd3 ? CLR_GO : RD_DEC;
                end
            end
            CLR_GO: begin
                wr       = 1'b1;
                addr     = 4'd14;
                result_d = err_q ? 128'd0 : shadow_q;
                state_d  = FIN;
            end
            FIN: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    assign AVM_READ      = rd;
    assign AVM_WRITE     = wr;
    assign AVM_CS        = rd | wr;
    assign AVM_BYTE_EN   = {4{rd | wr}};
    assign AVM_ADDR      = addr;
    assign AVM_WRITEDATA = wdata;
    assign CMD_DONE      = state_q == FIN;
    assign CMD_ERR       = (state_q == FIN) & err_q;
    assign CMD_BUSY      = (state_q != IDLE) | (CMD_START & RESET);
    assign RESULT        = result_q;
endmodule
